// File: rtl/md_pad_pkg.sv
// Shared constants and helpers for the six-button Mega Drive pad encoder:
// pin-pattern identifiers, phase limit, default idle timeout, and the
// phase-to-pattern decode used by the registered output mux.
package md_pad_pkg;

  localparam int         TIMEOUT_DEF = 24000;
  localparam logic [2:0] L_MAX       = 3'd5;

  typedef enum logic [2:0] {
    PAT_NORM_HI,
    PAT_NORM_LO,
    PAT_EXT_HI,
    PAT_ID_LO,
    PAT_F_LO
  } pat_e;

  // In 3-button mode every non-idle phase collapses to phase 1, which
  // hides the extended and ID patterns from the console.
  function automatic logic [2:0] eff_phase(input logic [2:0] l, input logic six);
    return (six || (l == 3'd0)) ? l : 3'd1;
  endfunction

  function automatic pat_e pat_select(input logic sel, input logic [2:0] le);
    if (sel) begin
      return (le == 3'd3) ? PAT_EXT_HI : PAT_NORM_HI;
    end else if (le == 3'd3) begin
      return PAT_ID_LO;
    end else if (le == 3'd4) begin
      return PAT_F_LO;
    end else begin
      return PAT_NORM_LO;
    end
  endfunction

endpackage

// File: rtl/md_sync.sv
// Parametrised multi-stage synchroniser for asynchronous pad/console inputs.
// The reset value lets idle-high lines come out of reset without a false edge.
module md_sync #(
  parameter int   STAGES  = 2,
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  // Shift the asynchronous input through the metastability chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= {STAGES{ {W{RST_VAL}} }};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/md_sixbutton_encoder_sync.sv
// Clocked six-button Mega Drive pad encoder. Counts select falling edges,
// returns to idle after a programmable quiet period, latches 3/6-button
// mode at reset and drives registered DB9 data pins.
module md_sixbutton_encoder_sync
  import md_pad_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p7,
  input  logic       up,
  input  logic       dw,
  input  logic       lf,
  input  logic       rg,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       st,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       md,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4,
  output logic       p6,
  output logic       p9,
  output logic [2:0] ph,
  output logic       six_en
);

  localparam logic [19:0] TMO = 20'(TIMEOUT_CYC);

  logic        sel_s, sel_d, md_s;
  logic [10:0] btn_s;
  logic        up_s, dw_s, lf_s, rg_s, a_s, b_s, c_s, st_s, x_s, y_s, z_s;
  logic        fall, rise, expired, cap;
  logic [19:0] tmr;
  logic [2:0]  l_q, l_nxt, le_nxt;
  logic [5:0]  pins_q, pins_nxt;
  pat_e        pat;

  md_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_sel (
    .clk(clk), .reset(reset), .d(p7), .q(sel_s)
  );

  md_sync #(.STAGES(SYNC_STAGES), .W(11), .RST_VAL(1'b1)) u_sync_btn (
    .clk(clk), .reset(reset),
    .d({up, dw, lf, rg, a, b, c, st, x, y, z}), .q(btn_s)
  );

  // The mode chain must keep tracking md while reset is held, so it is
  // never reset itself.
  md_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_md (
    .clk(clk), .reset(1'b0), .d(md), .q(md_s)
  );

  assign {up_s, dw_s, lf_s, rg_s, a_s, b_s, c_s, st_s, x_s, y_s, z_s} = btn_s;

  assign fall    = sel_d & ~sel_s;
  assign rise    = ~sel_d & sel_s;
  assign expired = (tmr == TMO);

  // Delayed select for edge detection; idles high so release is edge-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_d <= 1'b1;
    else       sel_d <= sel_s;
  end

  // Idle timer: cleared by either select edge, saturates at the timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             tmr <= '0;
    else if (fall | rise)  tmr <= '0;
    else if (!expired)     tmr <= tmr + 20'd1;
  end

  // Next phase: a fall on the expiry cycle starts a fresh sequence at 1
  always_comb begin
    l_nxt = l_q;
    if (fall) begin
      if (expired)           l_nxt = 3'd1;
      else if (l_q >= L_MAX) l_nxt = L_MAX;
      else                   l_nxt = l_q + 3'd1;
    end else if (expired) begin
      l_nxt = 3'd0;
    end
  end

  // Phase counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) l_q <= 3'd0;
    else       l_q <= l_nxt;
  end

  // Capture window: high during reset and for the first cycle after it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap <= 1'b1;
    else       cap <= 1'b0;
  end

  // Mode latch follows md inside the capture window, frozen afterwards
  always_ff @(posedge clk) begin
    if (cap) six_en <= md_s;
  end

  // Output mux is driven by the next phase so pins and ph change together
  always_comb begin
    le_nxt   = eff_phase(l_nxt, six_en);
    pat      = pat_select(sel_s, le_nxt);
    pins_nxt = 6'b111111;
    case (pat)
      PAT_NORM_HI: pins_nxt = {up_s, dw_s, lf_s, rg_s, b_s, c_s};
      PAT_EXT_HI:  pins_nxt = {z_s, y_s, x_s, md_s, b_s, c_s};
      PAT_NORM_LO: pins_nxt = {up_s, dw_s, 2'b00, a_s, st_s};
      PAT_ID_LO:   pins_nxt = {4'b0000, a_s, st_s};
      PAT_F_LO:    pins_nxt = {4'b1111, a_s, st_s};
      default:     pins_nxt = 6'b111111;
    endcase
  end

  // Registered DB9 data pins, all released while in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pins_q <= 6'b111111;
    else       pins_q <= pins_nxt;
  end

  assign {p1, p2, p3, p4, p6, p9} = pins_q;
  assign ph = eff_phase(l_q, six_en);

endmodule

// File: tb/tb_md_sixbutton_encoder_sync.sv
// Self-checking bench for md_sixbutton_encoder_sync (TIMEOUT_CYC=100).
module tb_md_sixbutton_encoder_sync;

  logic       clk = 1'b0;
  logic       reset, p7;
  logic       up, dw, lf, rg, a, b, c, st, x, y, z, md;
  logic       p1, p2, p3, p4, p6, p9;
  logic [2:0] ph;
  logic       six_en;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      name;
    logic [5:0] pins;
    logic [2:0] ph;
  } exp_t;

  typedef struct {
    string      name;
    logic       p7;
    logic [11:0] btn;
    int         hold;
    logic [5:0] pins;
    logic [2:0] ph;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[21];

  always #5 clk = ~clk;

  md_sixbutton_encoder_sync #(.TIMEOUT_CYC(100), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .p7(p7),
    .up(up), .dw(dw), .lf(lf), .rg(rg), .a(a), .b(b), .c(c), .st(st),
    .x(x), .y(y), .z(z), .md(md),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p6(p6), .p9(p9),
    .ph(ph), .six_en(six_en)
  );

  function automatic vec_t mk(string n, logic pv, logic [11:0] bt, int h,
                              logic [5:0] pn, logic [2:0] phv);
    vec_t v;
    v.name = n; v.p7 = pv; v.btn = bt; v.hold = h; v.pins = pn; v.ph = phv;
    return v;
  endfunction

  // Button order: up dw lf rg a b c st x y z md (1 = released)
  task automatic set_btn(input logic [11:0] v);
    {up, dw, lf, rg, a, b, c, st, x, y, z, md} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic expect_out(input string nm, input logic [5:0] pn, input logic [2:0] phv);
    exp_t e;
    e.name = nm; e.pins = pn; e.ph = phv;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_pins"}, {2'b00, p1, p2, p3, p4, p6, p9}, {2'b00, e.pins});
      chk({e.name, "_ph"}, {5'b0, ph}, {5'b0, e.ph});
    end
  endtask

  initial begin
    tbl[0]  = mk("lo1",          1'b0, 12'hF6F, 10,  6'b110000, 3'd1);
    tbl[1]  = mk("hi1",          1'b1, 12'hF6F, 10,  6'b111111, 3'd1);
    tbl[2]  = mk("lo2",          1'b0, 12'hF6F, 10,  6'b110000, 3'd2);
    tbl[3]  = mk("hi2",          1'b1, 12'hF6F, 10,  6'b111111, 3'd2);
    tbl[4]  = mk("lo3_id",       1'b0, 12'hF6F, 10,  6'b000000, 3'd3);
    tbl[5]  = mk("hi3",          1'b1, 12'hF6F, 10,  6'b111111, 3'd3);
    tbl[6]  = mk("lo4",          1'b0, 12'hF6F, 10,  6'b111100, 3'd4);
    tbl[7]  = mk("hi4",          1'b1, 12'hF6F, 10,  6'b111111, 3'd4);
    tbl[8]  = mk("lo5",          1'b0, 12'hF6F, 10,  6'b110000, 3'd5);
    tbl[9]  = mk("hi5",          1'b1, 12'hF6F, 10,  6'b111111, 3'd5);
    tbl[10] = mk("lo6_sat",      1'b0, 12'hF6F, 10,  6'b110000, 3'd5);
    tbl[11] = mk("hi_timeout",   1'b1, 12'hF6F, 120, 6'b111111, 3'd0);
    tbl[12] = mk("x_lo1",        1'b0, 12'hFF4, 10,  6'b110011, 3'd1);
    tbl[13] = mk("x_hi1",        1'b1, 12'hFF4, 10,  6'b111111, 3'd1);
    tbl[14] = mk("x_lo2",        1'b0, 12'hFF4, 10,  6'b110011, 3'd2);
    tbl[15] = mk("x_hi2",        1'b1, 12'hFF4, 10,  6'b111111, 3'd2);
    tbl[16] = mk("x_lo3_id",     1'b0, 12'hFF4, 10,  6'b000011, 3'd3);
    tbl[17] = mk("x_hi3_ext",    1'b1, 12'hFF4, 10,  6'b010011, 3'd3);
    tbl[18] = mk("x_hi_timeout", 1'b1, 12'hFF4, 120, 6'b111111, 3'd0);
    tbl[19] = mk("x_lo_new",     1'b0, 12'hFF4, 10,  6'b110011, 3'd1);
    tbl[20] = mk("x_hi_new",     1'b1, 12'hFF4, 10,  6'b111111, 3'd1);

    // Reset with md=1, everything released
    reset = 1'b1;
    p7    = 1'b1;
    set_btn(12'hFFF);
    step(6);
    chk("reset_pins", {2'b00, p1, p2, p3, p4, p6, p9}, 8'h3F);
    chk("reset_ph", {5'b0, ph}, 8'h00);
    reset = 1'b0;
    step(4);
    chk("six_en_md1", {7'b0, six_en}, 8'h01);
    expect_out("post_release", 6'b111111, 3'd0);
    compare_out();

    // Table-driven sequences: six-button counting, saturation, extended read
    for (int i = 0; i < 21; i++) begin
      p7 = tbl[i].p7;
      set_btn(tbl[i].btn);
      expect_out(tbl[i].name, tbl[i].pins, tbl[i].ph);
      step(tbl[i].hold);
      compare_out();
    end

    // Latency: select and button changes reach the pins after 3 cycles
    set_btn(12'hFFF);
    step(120);
    p7 = 1'b0;
    step(2);
    expect_out("lat_sel_2cyc", 6'b111111, 3'd0);
    compare_out();
    step(1);
    expect_out("lat_sel_3cyc", 6'b110011, 3'd1);
    compare_out();
    up = 1'b0;
    step(2);
    expect_out("lat_btn_2cyc", 6'b110011, 3'd1);
    compare_out();
    step(1);
    expect_out("lat_btn_3cyc", 6'b010011, 3'd1);
    compare_out();
    up = 1'b1;
    p7 = 1'b1;

    // Timeout boundary, measured from the last (rising) edge
    step(120);
    p7 = 1'b0;
    step(10);
    p7 = 1'b1;
    step(100);
    p7 = 1'b0;
    step(6);
    expect_out("idle99_fall", 6'b110011, 3'd2);
    compare_out();
    p7 = 1'b1;
    step(101);
    p7 = 1'b0;
    step(6);
    expect_out("fall_on_expiry", 6'b110011, 3'd1);
    compare_out();
    p7 = 1'b1;
    step(103);
    expect_out("idle_99_holds", 6'b111111, 3'd1);
    compare_out();
    step(1);
    expect_out("idle_100_clears", 6'b111111, 3'd0);
    compare_out();

    // Asynchronous reset while the extended pattern is on the pins
    set_btn(12'hFF5);
    for (int i = 0; i < 3; i++) begin
      p7 = 1'b0;
      step(10);
      p7 = 1'b1;
      step(10);
    end
    expect_out("pre_reset_ext", 6'b010111, 3'd3);
    compare_out();
    #2;
    reset = 1'b1;
    #1;
    expect_out("reset_async", 6'b111111, 3'd0);
    compare_out();
    @(negedge clk);
    step(4);
    reset = 1'b0;
    step(4);
    chk("six_en_md1_again", {7'b0, six_en}, 8'h01);
    p7 = 1'b0;
    step(6);
    expect_out("post_reset_lo1", 6'b110011, 3'd1);
    compare_out();
    p7 = 1'b1;
    step(10);

    // 3-button compatibility: md held low at reset
    reset = 1'b1;
    set_btn(12'hF6E);
    step(6);
    reset = 1'b0;
    step(4);
    chk("six_en_md0", {7'b0, six_en}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      p7 = 1'b0;
      expect_out($sformatf("b3_lo%0d", i + 1), 6'b110000, 3'd1);
      step(10);
      compare_out();
      p7 = 1'b1;
      expect_out($sformatf("b3_hi%0d", i + 1), 6'b111111, 3'd1);
      step(10);
      compare_out();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
